// File: rtl/ic_refill_responder.sv
// Purpose  : L2-side instruction-cache line refill. Fetches one B-byte line as NB = B/8
//            in-order 64-bit beats into a local buffer, then streams it to the set.
// Latency  : memory always ready, response latency L -> miss to first grant = NB + L + 1
//            cycles; grant is then high for exactly NB consecutive cycles.
// Backpress: memory requests wait on mem_ready_i and at most NB are ever outstanding.
//            The stream is never paused; the set drops ic_miss_i to abandon a fill.
//
// Ports:
//   clk_i, reset_ni                  clock; asynchronous active-low reset
//   ic_miss_i, ic_miss_addr_i        miss request and PC of the missing fetch
//   ic_repl_grant_o, rep_word_o      refill grant and current beat (0 when no grant)
//   mem_req_o, mem_addr_o            backing-memory read request, 8-byte aligned address
//   mem_ready_i                      request accepted when mem_req_o && mem_ready_i
//   mem_rvalid_i, mem_rdata_i        in-order read responses
//   refill_cnt_o, stall_cnt_o        performance counters, only with IC_REFILL_PERF_EN
//
// Optional feature macro: IC_REFILL_PERF_EN adds the two saturating 32-bit counters.

module ic_refill_responder #(
   parameter int B      = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              ic_miss_i,
   input  logic [ADDR_W-1:0] ic_miss_addr_i,
   output logic              ic_repl_grant_o,
   output logic [63:0]       rep_word_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ready_i,
   input  logic              mem_rvalid_i,
   input  logic [63:0]       mem_rdata_i
`ifdef IC_REFILL_PERF_EN
   ,
   output logic [31:0]       refill_cnt_o,
   output logic [31:0]       stall_cnt_o
`endif
);

   localparam int NB = B / 8;          // beats per line
   localparam int LB = $clog2(B);      // byte-offset bits within a line
   localparam int IW = $clog2(NB);     // beat index width
   localparam int CW = IW + 1;         // counters must be able to hold NB itself

   localparam logic [CW-1:0] NB_C = CW'(NB);
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   typedef enum logic [3:0] {
      S_IDLE   = 4'b0001,
      S_FETCH  = 4'b0010,
      S_DRAIN  = 4'b0100,
      S_STREAM = 4'b1000
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       iss_q, iss_d;      // requests accepted by memory
   logic [CW-1:0]       rcv_q, rcv_d;      // responses consumed
   logic [CW-1:0]       k_q, k_d;          // stream beat index
   logic [ADDR_W-1:0]   base_q, base_d;    // line-aligned base of the refill
   logic [63:0]         line_buf [NB];

   logic                accept;
   logic                resp_ok;
   logic                line_hit;
   logic                fetch_abort;
   logic [CW-1:0]       iss_inc;
   logic [CW-1:0]       rcv_inc;

   // The byte offset within the line never matters; only the line number is compared.
   logic                unused_offset;
   assign unused_offset = ^ic_miss_addr_i[LB-1:0];

   // ------------------------------------------------------------------
   // Request / response bookkeeping
   // ------------------------------------------------------------------
   assign mem_req_o  = (state_q == S_FETCH) && (iss_q < NB_C);
   assign mem_addr_o = mem_req_o ? (base_q + ADDR_W'({iss_q, 3'b000})) : '0;
   assign accept     = mem_req_o && mem_ready_i;

   // Responses only count while something is outstanding; a response with
   // rcv == iss is a memory protocol error (or a leftover from before a reset)
   // and is dropped. Outside FETCH/DRAIN nothing is in flight from our side.
   assign resp_ok = mem_rvalid_i && (rcv_q != iss_q) &&
                    ((state_q == S_FETCH) || (state_q == S_DRAIN));

   assign iss_inc = iss_q + {{(CW-1){1'b0}}, accept};
   assign rcv_inc = rcv_q + {{(CW-1){1'b0}}, resp_ok};

   // The set has abandoned this line if it stopped missing or now misses a different line.
   assign line_hit    = (ic_miss_addr_i[ADDR_W-1:LB] == base_q[ADDR_W-1:LB]);
   assign fetch_abort = !ic_miss_i || !line_hit;

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      iss_d   = iss_q;
      rcv_d   = rcv_q;
      k_d     = k_q;
      base_d  = base_q;

      unique case (state_q)
         S_IDLE: begin
            if (ic_miss_i) begin
               base_d  = {ic_miss_addr_i[ADDR_W-1:LB], {LB{1'b0}}};
               iss_d   = '0;
               rcv_d   = '0;
               state_d = S_FETCH;
            end
         end

         S_FETCH: begin
            iss_d = iss_inc;
            rcv_d = rcv_inc;
            if (fetch_abort) begin
               // mem_req_o is still high this cycle, so a request accepted now is
               // already counted in iss_inc and its response must be drained too.
               state_d = (iss_inc != rcv_inc) ? S_DRAIN : S_IDLE;
            end else if (resp_ok && (rcv_q == LAST)) begin
               k_d     = '0;
               state_d = S_STREAM;
            end
         end

         S_DRAIN: begin
            rcv_d = rcv_inc;
            if (rcv_inc == iss_q) begin
               state_d = S_IDLE;
            end
         end

         S_STREAM: begin
            k_d = k_q + CW'(1);
            // A dropped miss ends the burst; the set has already discarded its partial fill.
            if (!ic_miss_i || (k_q == LAST)) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q <= S_IDLE;
         iss_q   <= '0;
         rcv_q   <= '0;
         k_q     <= '0;
         base_q  <= '0;
      end else begin
         state_q <= state_d;
         iss_q   <= iss_d;
         rcv_q   <= rcv_d;
         k_q     <= k_d;
         base_q  <= base_d;
      end
   end

   // Line buffer: contents are meaningless until a fill completes, so no reset.
   always_ff @(posedge clk_i) begin
      if ((state_q == S_FETCH) && resp_ok) begin
         line_buf[rcv_q[IW-1:0]] <= mem_rdata_i;
      end
   end

   // ------------------------------------------------------------------
   // Refill stream
   // ------------------------------------------------------------------
   assign ic_repl_grant_o = (state_q == S_STREAM);
   assign rep_word_o      = ic_repl_grant_o ? line_buf[k_q[IW-1:0]] : 64'd0;

`ifdef IC_REFILL_PERF_EN
   // ------------------------------------------------------------------
   // Performance counters (saturating)
   // ------------------------------------------------------------------
   logic [31:0] refill_cnt_q;
   logic [31:0] stall_cnt_q;

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         refill_cnt_q <= '0;
         stall_cnt_q  <= '0;
      end else begin
         // A STREAM is complete once its last beat has been presented.
         if ((state_q == S_STREAM) && (k_q == LAST) && (refill_cnt_q != 32'hFFFF_FFFF)) begin
            refill_cnt_q <= refill_cnt_q + 32'd1;
         end
         // Cycles the set spends waiting on the backing memory.
         if (((state_q == S_FETCH) || (state_q == S_DRAIN)) && ic_miss_i &&
             (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
      end
   end

   assign refill_cnt_o = refill_cnt_q;
   assign stall_cnt_o  = stall_cnt_q;
`endif

endmodule
